// File: rtl/mem_cntrl_if.sv
// Memory-side line port of mem_cntrl: one request channel (read or write line)
// and a single-cycle read-response channel.
interface mem_cntrl_if #(
    parameter int ADDR_W = 64,
    parameter int LINE_W = 512
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_wr_data;
    logic              mem_rsp_valid;
    logic [LINE_W-1:0] mem_rd_data;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_wr_data,
        input  mem_req_ready, mem_rsp_valid, mem_rd_data
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_wr_data,
        output mem_req_ready, mem_rsp_valid, mem_rd_data
    );
endinterface

// File: rtl/mem_cntrl.sv
// Line-transfer memory controller: turns word-serial CPU reads/writes into
// single 16-word line transactions on the memory port. All outputs registered.
module mem_cntrl #(
    parameter int WORDS  = 16,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] io_address,
    input  logic [31:0]       cpu_data_in,
    output logic [31:0]       cpu_data_out,
    output logic              rd_valid,
    output logic              tx_done,
    mem_cntrl_if.master       mem
);
    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, RD_STREAM, WR_FILL, WR_REQ, DONE
    } state_e;

    localparam logic [1:0]        OP_READ   = 2'b01;
    localparam logic [1:0]        OP_WRITE  = 2'b11;
    localparam logic [3:0]        LAST_IDX  = 4'd15;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(63);

    state_e                  state_q, state_d;
    logic [3:0]              idx_q, idx_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [WORDS-1:0][31:0]  line_q;
    logic                    req_valid_q, req_valid_d;
    logic                    req_we_q, req_we_d;
    logic                    rd_valid_d, tx_done_d;
    logic [31:0]             data_out_d;
    logic                    buf_load, buf_wr;

    // NOTE: every registered signal uses <= so all flops update from the same
    // pre-edge values; a blocking = here would create ordering-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every signal written below gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        req_valid_d = 1'b0;
        req_we_d    = 1'b0;
        rd_valid_d  = 1'b0;
        tx_done_d   = 1'b0;
        data_out_d  = '0;
        buf_load    = 1'b0;
        buf_wr      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (op == OP_READ) begin
                    addr_d      = io_address & LINE_MASK;
                    state_d     = RD_REQ;
                    req_valid_d = 1'b1;
                end else if (op == OP_WRITE) begin
                    addr_d  = io_address & LINE_MASK;
                    idx_d   = '0;
                    state_d = WR_FILL;
                end
            end
            RD_REQ: begin
                if (mem.mem_req_ready) state_d     = RD_WAIT;
                else                   req_valid_d = 1'b1;
            end
            RD_WAIT: begin
                // Word 0 is presented straight from the response so the stream
                // starts the cycle after mem_rsp_valid.
                if (mem.mem_rsp_valid) begin
                    buf_load   = 1'b1;
                    idx_d      = '0;
                    state_d    = RD_STREAM;
                    rd_valid_d = 1'b1;
                    data_out_d = mem.mem_rd_data[31:0];
                end
            end
            RD_STREAM: begin
                // idx_q is the word on cpu_data_out this cycle.
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d      = idx_q + 4'd1;
                    rd_valid_d = 1'b1;
                    data_out_d = line_q[idx_q + 4'd1];
                    tx_done_d  = (idx_q + 4'd1 == LAST_IDX);
                end
            end
            WR_FILL: begin
                buf_wr = 1'b1;
                idx_d  = idx_q + 4'd1;
                if (idx_q == LAST_IDX) begin
                    state_d     = WR_REQ;
                    req_valid_d = 1'b1;
                    req_we_d    = 1'b1;
                end
            end
            WR_REQ: begin
                if (mem.mem_req_ready) begin
                    state_d   = DONE;
                    tx_done_d = 1'b1;
                end else begin
                    req_valid_d = 1'b1;
                    req_we_d    = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            addr_q       <= '0;
            req_valid_q  <= 1'b0;
            req_we_q     <= 1'b0;
            rd_valid     <= 1'b0;
            tx_done      <= 1'b0;
            cpu_data_out <= '0;
        end else begin
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            req_valid_q  <= req_valid_d;
            req_we_q     <= req_we_d;
            rd_valid     <= rd_valid_d;
            tx_done      <= tx_done_d;
            cpu_data_out <= data_out_d;
        end
    end

    // NOTE: the line buffer is reset along with the control state because it
    // drives mem_wr_data directly and must read as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        line_q         <= '0;
        else if (buf_load) line_q         <= mem.mem_rd_data;
        else if (buf_wr)   line_q[idx_q]  <= cpu_data_in;
    end

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_we    = req_we_q;
    assign mem.mem_req_addr  = addr_q;
    assign mem.mem_wr_data   = line_q;
endmodule

// File: tb/tb_mem_cntrl.sv
// Self-checking bench for mem_cntrl: directed and randomized line transfers
// against a bench-side memory model and cycle-exact expectations.
module tb_mem_cntrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  op;
    logic [63:0] io_address;
    logic [31:0] cpu_data_in;
    logic [31:0] cpu_data_out;
    logic        rd_valid;
    logic        tx_done;

    int checks = 0;
    int failures = 0;
    int tx_count = 0;

    logic [511:0] mem_model [logic [63:0]];
    logic [63:0]  known_addrs [$];

    mem_cntrl_if bus ();

    mem_cntrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .io_address   (io_address),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .rd_valid     (rd_valid),
        .tx_done      (tx_done),
        .mem          (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tx_done) tx_count++;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [511:0] seq_line(input logic [31:0] base);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_valid"},  512'(rd_valid),          '0);
        check({tag, "_tx_done"},   512'(tx_done),           '0);
        check({tag, "_data_out"},  512'(cpu_data_out),      '0);
        check({tag, "_req_valid"}, 512'(bus.mem_req_valid), '0);
        check({tag, "_req_we"},    512'(bus.mem_req_we),    '0);
        check({tag, "_req_addr"},  512'(bus.mem_req_addr),  '0);
        check({tag, "_wr_data"},   bus.mem_wr_data,         '0);
    endtask

    // One CPU read of a line; the memory answers with the given line. abort_at >= 0
    // pulls reset while that stream word is on the bus.
    task automatic do_read(input logic [63:0] addr, input logic [511:0] line,
                           input int rdy_dly, input int rsp_dly, input int abort_at,
                           output logic [511:0] got);
        logic [63:0] exp_addr;
        exp_addr = addr & ~64'h3F;
        got = '0;
        op = 2'b01;
        io_address = addr;
        tick();
        op = 2'b00;
        io_address = {$urandom, $urandom};
        for (int d = 0; d < rdy_dly; d++) begin
            check("rd_req_valid_wait", 512'(bus.mem_req_valid), 512'(1'b1));
            check("rd_req_addr_wait",  512'(bus.mem_req_addr),  512'(exp_addr));
            tick();
        end
        bus.mem_req_ready = 1'b1;
        check("rd_req_valid", 512'(bus.mem_req_valid), 512'(1'b1));
        check("rd_req_we",    512'(bus.mem_req_we),    '0);
        check("rd_req_addr",  512'(bus.mem_req_addr),  512'(exp_addr));
        tick();
        bus.mem_req_ready = 1'b0;
        for (int d = 0; d < rsp_dly; d++) begin
            check("rd_wait_valid",    512'(bus.mem_req_valid), '0);
            check("rd_wait_rd_valid", 512'(rd_valid),          '0);
            tick();
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rd_data = line;
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rd_data = rand_line();
        for (int i = 0; i < 16; i++) begin
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("abort");
                @(posedge clk);
                #2;
                rst_n = 1'b1;
                return;
            end
            check("stream_rd_valid", 512'(rd_valid),     512'(1'b1));
            check("stream_data",     512'(cpu_data_out), 512'(line[32*i +: 32]));
            check("stream_tx_done",  512'(tx_done),      512'(i == 15));
            got[32*i +: 32] = cpu_data_out;
            tick();
        end
        check("rd_end_rd_valid", 512'(rd_valid),          '0);
        check("rd_end_tx_done",  512'(tx_done),           '0);
        check("rd_end_valid",    512'(bus.mem_req_valid), '0);
    endtask

    // One CPU write: words of the data argument are fed over 16 cycles; the exp
    // argument is the line the memory must receive. spurious adds stray
    // rsp_valid and op=01 pulses.
    task automatic do_write(input logic [63:0] addr, input logic [511:0] data,
                            input logic [511:0] exp, input int rdy_dly, input bit spurious);
        logic [63:0] exp_addr;
        exp_addr = addr & ~64'h3F;
        op = 2'b11;
        io_address = addr;
        tick();
        op = 2'b00;
        for (int i = 0; i < 16; i++) begin
            cpu_data_in = data[32*i +: 32];
            if (spurious) begin
                bus.mem_rsp_valid = (i % 3 == 0);
                bus.mem_rd_data = rand_line();
                op = (i % 4 == 1) ? 2'b01 : 2'b00;
                io_address = {$urandom, $urandom};
            end
            check("fill_req_valid", 512'(bus.mem_req_valid), '0);
            check("fill_rd_valid",  512'(rd_valid),          '0);
            tick();
        end
        op = 2'b00;
        bus.mem_rsp_valid = 1'b0;
        cpu_data_in = $urandom;
        for (int d = 0; d < rdy_dly; d++) begin
            check("wr_hold_valid", 512'(bus.mem_req_valid), 512'(1'b1));
            check("wr_hold_we",    512'(bus.mem_req_we),    512'(1'b1));
            check("wr_hold_data",  bus.mem_wr_data,         exp);
            check("wr_hold_addr",  512'(bus.mem_req_addr),  512'(exp_addr));
            check("wr_hold_done",  512'(tx_done),           '0);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        check("wr_req_valid", 512'(bus.mem_req_valid), 512'(1'b1));
        check("wr_req_we",    512'(bus.mem_req_we),    512'(1'b1));
        check("wr_req_data",  bus.mem_wr_data,         exp);
        check("wr_req_addr",  512'(bus.mem_req_addr),  512'(exp_addr));
        tick();
        bus.mem_req_ready = 1'b0;
        check("wr_done_pulse", 512'(tx_done),           512'(1'b1));
        check("wr_done_valid", 512'(bus.mem_req_valid), '0);
        tick();
        check("wr_done_single", 512'(tx_done), '0);
        mem_model[exp_addr] = exp;
    endtask

    initial begin
        logic [511:0] got, line, got2;
        logic [63:0]  a;
        int           tc;

        op = 2'b00;
        io_address = '0;
        cpu_data_in = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Zero-wait read of 0x47: line address 0x40, tx_done with word 15.
        tc = tx_count;
        do_read(64'h47, seq_line(32'hA000_0000), 0, 0, -1, got);
        check("zero_wait_tx_count", 512'(tx_count - tc), 512'(1));

        // Stray responses while idle.
        for (int i = 0; i < 3; i++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rd_data = rand_line();
            check("idle_rsp_rd_valid", 512'(rd_valid),          '0);
            check("idle_rsp_valid",    512'(bus.mem_req_valid), '0);
            tick();
        end
        bus.mem_rsp_valid = 1'b0;

        // Write with five cycles of backpressure.
        do_write(64'h400, seq_line(32'h0), seq_line(32'h0), 5, 1'b0);

        // Loopback: read a line, CPU writes the streamed words back to 0x400.
        tc = tx_count;
        line = seq_line(32'h1111_0000);
        do_read(64'h800, line, 1, 2, -1, got);
        do_write(64'h400, got, line, 2, 1'b1);
        check("loopback_tx_count", 512'(tx_count - tc), 512'(2));

        // Reserved op never starts a transaction.
        op = 2'b10;
        for (int i = 0; i < 20; i++) begin
            check("reserved_req_valid", 512'(bus.mem_req_valid), '0);
            check("reserved_tx_done",   512'(tx_done),           '0);
            tick();
        end
        op = 2'b00;

        // Reset at stream word 7, then a clean read from word 0.
        tc = tx_count;
        do_read(64'h1234, rand_line(), 0, 1, 7, got);
        check("abort_no_tx_done", 512'(tx_count - tc), '0);
        tick();
        check_all_zero("post_abort");
        line = rand_line();
        do_read(64'h1234, line, 1, 0, -1, got);
        check("post_abort_line", got, line);

        // Randomized mix of reads and writes against the memory model.
        for (int n = 0; n < 16; n++) begin
            if (known_addrs.size() != 0 && $urandom_range(0, 1) == 1) begin
                a = known_addrs[$urandom_range(0, known_addrs.size() - 1)];
                line = mem_model[a];
                do_read(a | 64'($urandom_range(0, 63)), line,
                        $urandom_range(0, 3), $urandom_range(0, 3), -1, got2);
                check("rand_read_line", got2, line);
            end else begin
                a = {$urandom, $urandom} & ~64'h3F;
                line = rand_line();
                do_write(a | 64'($urandom_range(0, 63)), line, line,
                         $urandom_range(0, 4), 1'($urandom_range(0, 1)));
                known_addrs.push_back(a);
            end
            repeat ($urandom_range(0, 2)) begin
                check("gap_rd_valid", 512'(rd_valid), '0);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_cntrl.md
# mem_cntrl

Line-transfer memory controller between the `cpu` DMA-loopback client and the memory-side line port. It turns a word-serial CPU request (`op`, `io_address`, 32-bit data buses) into single 512-bit (16 × 32-bit) line transactions. Reads are returned to the CPU as a 16-word stream qualified by `rd_valid`. Writes are collected as 16 words from the CPU and then issued as one line.

## Interface

Parameters:
- `WORDS`, 16: words per line; the design is fixed at 16 with a 4-bit index.
- `ADDR_W`, 64: address width.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `op` input 2: CPU operation. 00 = none, 01 = read, 11 = write, 10 = reserved (treated as none).
- `io_address` input 64: CPU line address. Bits [5:0] are ignored.
- `cpu_data_in` input 32: write data from the CPU (the CPU's `common_data_bus_out`).
- `cpu_data_out` output 32: read data to the CPU (the CPU's `common_data_bus_in`).
- `rd_valid` output 1: `cpu_data_out` holds a valid read word this cycle.
- `tx_done` output 1: one-cycle pulse marking transaction completion.
- `mem_req_valid` output 1: line request valid.
- `mem_req_ready` input 1: memory accepts the request.
- `mem_req_we` output 1: 1 = write, 0 = read.
- `mem_req_addr` output 64: line address, with [5:0] forced to 0.
- `mem_wr_data` output 512: write line. Word i is at [32i+31:32i].
- `mem_rsp_valid` input 1: read line valid on `mem_rd_data` (single cycle).
- `mem_rd_data` input 512: read line, same word packing as `mem_wr_data`.

## Operation

- **FSM states:** IDLE, RD_REQ, RD_WAIT, RD_STREAM, WR_FILL, WR_REQ, DONE.
- **IDLE**
  - `op`=01: latch `io_address` and go to RD_REQ.
  - `op`=11: latch the address, clear the word index and go to WR_FILL.
  - Any other `op`: stay in IDLE.
- **RD_REQ:** `mem_req_valid`=1, `mem_req_we`=0. On `mem_req_ready`, go to RD_WAIT.
- **RD_WAIT:** on `mem_rsp_valid`, capture `mem_rd_data` into the line buffer, clear the index and go to RD_STREAM.
- **RD_STREAM:** each cycle, `rd_valid`=1 and `cpu_data_out` = buffer word[index]; the index increments.
  - At index 15, assert `tx_done` and go to IDLE. The index wraps to 0.
- **WR_FILL:** each cycle, store `cpu_data_in` into buffer word[index]; the index increments.
  - After the store at index 15, go to WR_REQ.
- **WR_REQ:** `mem_req_valid`=1, `mem_req_we`=1, `mem_wr_data` = buffer. On `mem_req_ready`, go to DONE.
- **DONE:** `tx_done`=1 for one cycle, then go to IDLE.
- **Stable outputs while valid:** `mem_req_addr`, `mem_req_we` and `mem_wr_data` stay constant while `mem_req_valid`=1. `mem_req_valid` never drops before the handshake.
- **Ignored inputs:**
  - `mem_rsp_valid` is ignored outside RD_WAIT.
  - `op` and `io_address` are ignored outside IDLE; a change mid-transaction has no effect.
- **Repeated `op`:** if `op` is still asserted on return to IDLE, a new transaction starts. This is the intended loopback behaviour.
- **Reset values:** all outputs 0, line buffer 0, index 0, state IDLE.
- **Reset mid-transaction:** abandons the transaction immediately. `mem_req_valid` deasserts asynchronously and no `tx_done` is produced.

## Timing

- All outputs are registered.
- **Read:** `op`=01 sampled in IDLE at cycle 0.
  - `mem_req_valid` is high from cycle 1.
  - If the handshake is at cycle h and `mem_rsp_valid` at cycle r > h, the stream occupies cycles r+1..r+16, with words 0..15 in order.
  - `tx_done` is high only at cycle r+16, coincident with word 15.
  - The FSM is in IDLE at cycle r+17.
- **Write:** `op`=11 sampled at cycle 0.
  - `cpu_data_in` is captured at cycles 1..16 as words 0..15.
  - `mem_req_valid` is high from cycle 17 until `mem_req_ready`.
  - If the handshake is at cycle h, `tx_done` is high at h+1 and the FSM is in IDLE at h+2.
- **Zero-wait case:** `mem_req_ready` tied 1 gives a write `tx_done` at cycle 18. A read with `mem_rsp_valid` at cycle 2 gives `tx_done` at cycle 18.
- `rd_valid` is never asserted outside RD_STREAM.

## Test plan

- **Read, zero wait:** reset, `op`=01, `io_address`=0x47, `mem_req_ready`=1, response word i = 0xA000_0000+i at cycle 2.
  - `mem_req_addr`=0x40.
  - `rd_valid` cycles 3..18 with data 0xA000_0000..0xA000_000F.
  - `tx_done` only at cycle 18.
- **Write with backpressure:** `op`=11, address 0x400, `cpu_data_in` = i at capture cycle i+1; `mem_req_ready` low for 5 cycles after cycle 17.
  - `mem_req_valid` is held with stable `mem_wr_data` words 0..15 = 0..15.
  - `mem_req_we`=1.
  - `tx_done` is a single pulse at the cycle after the handshake.
- **Loopback with the `cpu` block:** read a line of 0x1111_0000+i, then the CPU writes it back to 0x400.
  - The write line received at 0x400 equals the read line.
  - Exactly two `tx_done` pulses occur.
- **Spurious inputs:**
  - `mem_rsp_valid` pulses while in IDLE and WR_FILL produce no `rd_valid` and no buffer corruption.
  - `op` toggled to 01 during WR_FILL is ignored.
- **Reset mid-stream:** assert `rst_n`=0 at stream word 7.
  - All outputs are immediately 0 and the state is IDLE.
  - After release, a fresh read completes normally with index starting at word 0.
- **Reserved op:** `op`=10 for 20 cycles gives no `mem_req_valid` and no `tx_done`.
